// File: rtl/stream_arbiter_pkg.sv
// Shared definitions for the stream arbiter: FSM encoding and a width helper.
package stream_arbiter_pkg;

    localparam logic ST_IDLE_ENC = 1'b0;
    localparam logic ST_BUSY_ENC = 1'b1;

    typedef enum logic {
        ST_IDLE = ST_IDLE_ENC,
        ST_BUSY = ST_BUSY_ENC
    } arb_state_t;

    // Index width for n items, never below 1 so a 2-port arbiter still has an id bit.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/stream_arbiter_if.sv
// Bundled input/output stream handshake of the arbiter.
interface stream_arbiter_if
    import stream_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_PORTS  = 4
);
    localparam int ID_W = clog2(NUM_PORTS);

    logic [NUM_PORTS*DATA_WIDTH-1:0] in_data;
    logic [NUM_PORTS-1:0]            in_last;
    logic [NUM_PORTS-1:0]            in_valid;
    logic [NUM_PORTS-1:0]            in_ready;
    logic [DATA_WIDTH-1:0]           out_data;
    logic                            out_last;
    logic [ID_W-1:0]                 out_id;
    logic                            out_valid;
    logic                            out_ready;

    modport slave (
        input  in_data, in_last, in_valid, out_ready,
        output in_ready, out_data, out_last, out_id, out_valid
    );

    modport master (
        output in_data, in_last, in_valid, out_ready,
        input  in_ready, out_data, out_last, out_id, out_valid
    );

endinterface

// File: rtl/stream_arbiter_rr_select.sv
// Round-robin pick: first set request bit searching circularly from rr_ptr+1.
module stream_arbiter_rr_select
    import stream_arbiter_pkg::*;
#(
    parameter int NUM_PORTS = 4
) (
    input  logic [NUM_PORTS-1:0]        req,
    input  logic [clog2(NUM_PORTS)-1:0] rr_ptr,
    output logic [clog2(NUM_PORTS)-1:0] next,
    output logic                        any
);
    localparam int ID_W = clog2(NUM_PORTS);
    localparam int DW   = clog2(2 * NUM_PORTS);

    logic [2*NUM_PORTS-1:0] req_dbl;
    logic [NUM_PORTS-1:0]   rot;
    logic [ID_W-1:0]        start;
    logic [ID_W-1:0]        offset;
    logic [ID_W:0]          sum;

    assign req_dbl = {req, req};
    assign start   = (rr_ptr == ID_W'(NUM_PORTS - 1)) ? '0 : rr_ptr + ID_W'(1);

    // Doubling the vector turns the circular search into a plain window select.
    always_comb begin
        rot = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            rot[i] = req_dbl[DW'(start) + DW'(i)];
        end
    end

    always_comb begin
        any    = 1'b0;
        offset = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (rot[i]) begin
                any    = 1'b1;
                offset = ID_W'(i);
            end
        end
    end

    assign sum  = {1'b0, start} + {1'b0, offset};
    assign next = (sum >= (ID_W+1)'(NUM_PORTS)) ? ID_W'(sum - (ID_W+1)'(NUM_PORTS)) : ID_W'(sum);

endmodule

// File: rtl/stream_arbiter.sv
// Round-robin stream arbiter: NUM_PORTS inputs share one output, optionally holding
// the grant for a whole packet.
//   state   | meaning
//   IDLE    | no grant; outputs quiet, waiting for any eligible request
//   BUSY    | grant_q owns the output; data/valid/last pass straight through
module stream_arbiter
    import stream_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_PORTS   = 4,
    parameter bit PACKET_MODE = 1'b1
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [NUM_PORTS-1:0] cfg_mask,
    stream_arbiter_if.slave      bus
);
    localparam int ID_W = clog2(NUM_PORTS);

    arb_state_t            state_q, state_d;
    logic [ID_W-1:0]       grant_q, grant_d;
    logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]       next_idx;
    logic                  next_any;
    logic [NUM_PORTS-1:0]  req;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_valid;
    logic                  sel_last;
    logic                  grant_done;

    assign req = bus.in_valid & cfg_mask;

    stream_arbiter_rr_select #(
        .NUM_PORTS (NUM_PORTS)
    ) u_rr_select (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .next   (next_idx),
        .any    (next_any)
    );

    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_q == ID_W'(i)) begin
                sel_data  = bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
                sel_valid = bus.in_valid[i];
                sel_last  = bus.in_last[i];
            end
        end
    end

    assign grant_done = sel_valid && bus.out_ready && (sel_last || !PACKET_MODE);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= ID_W'(NUM_PORTS - 1);
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        rr_ptr_d      = rr_ptr_q;
        bus.out_valid = 1'b0;
        bus.out_data  = '0;
        bus.out_last  = 1'b0;
        bus.out_id    = '0;
        bus.in_ready  = '0;
        case (state_q)
            ST_IDLE: begin
                if (next_any) begin
                    grant_d  = next_idx;
                    rr_ptr_d = next_idx;
                    state_d  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                bus.out_valid = sel_valid;
                bus.out_data  = sel_data;
                bus.out_last  = sel_last;
                bus.out_id    = grant_q;
                for (int i = 0; i < NUM_PORTS; i++) begin
                    if (grant_q == ID_W'(i)) bus.in_ready[i] = bus.out_ready;
                end
                // The finishing input stays in req, so it competes last but is not excluded.
                if (grant_done) begin
                    if (next_any) begin
                        grant_d  = next_idx;
                        rr_ptr_d = next_idx;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule
